// File: rtl/security_lock_ctrl.sv
// ----------------------------------------------------------------------------
// security_lock_ctrl
//
// Purpose:
//   Lock controller sitting behind a 3-bit code comparator. When a code entry
//   completes it enables the comparator, takes its sticky pass/fail result
//   (or times out), clears it again, and then either releases the door for a
//   fixed time or counts a failure. Too many consecutive failures enter a
//   timed lockout with the alarm driven.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   enter       in   one-cycle pulse: code entry complete
//   match       in   comparator pass flag (sticky)
//   not_match   in   comparator fail flag (sticky)
//   check       out  enables comparison in the comparator
//   cmp_clear   out  clears the comparator
//   unlocked    out  door release
//   locked_out  out  lockout active
//   alarm       out  alarm drive
//   busy        out  controller not idle
//   fail_count  out  consecutive failed attempts
// ----------------------------------------------------------------------------
module security_lock_ctrl #(
   parameter int MAX_TRIES      = 3,
   parameter int UNLOCK_CYCLES  = 8,
   parameter int LOCKOUT_CYCLES = 16,
   parameter int RESP_TIMEOUT   = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enter,
   input  logic                             match,
   input  logic                             not_match,
   output logic                             check,
   output logic                             cmp_clear,
   output logic                             unlocked,
   output logic                             locked_out,
   output logic                             alarm,
   output logic                             busy,
   output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

   localparam int FC_W = $clog2(MAX_TRIES + 1);

   // The shared timer only ever holds (duration - 1), so size it for the
   // largest of the three durations.
   localparam int CNT_MAX_A = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > RESP_TIMEOUT) ? CNT_MAX_A : RESP_TIMEOUT;
   localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] LOAD_RESP    = CNT_W'(RESP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LOAD_UNLOCK  = CNT_W'(UNLOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_LOCKOUT = CNT_W'(LOCKOUT_CYCLES - 1);

   // A failure while fail_count is below this value does not yet lock out.
   localparam logic [FC_W-1:0]  LAST_FAIL    = FC_W'(MAX_TRIES - 1);
   localparam logic [FC_W-1:0]  FAIL_SAT     = FC_W'(MAX_TRIES);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CHECK   = 3'd1;
   localparam logic [2:0] S_CLEAR   = 3'd2;
   localparam logic [2:0] S_UNLOCK  = 3'd3;
   localparam logic [2:0] S_LOCKOUT = 3'd4;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             pass;
   // Keeps cmp_clear high while reset is being applied so the comparator is
   // cleared together with this block; drops on the first non-reset edge.
   logic             rst_clr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         pass       <= 1'b0;
         fail_count <= '0;
         rst_clr    <= 1'b1;
      end else begin
         rst_clr <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enter) begin
                  state <= S_CHECK;
                  cnt   <= LOAD_RESP;
               end
            end

            // A flag on the last timeout edge wins because it is tested first.
            S_CHECK: begin
               if (match) begin
                  pass  <= 1'b1;
                  state <= S_CLEAR;
               end else if (not_match) begin
                  pass  <= 1'b0;
                  state <= S_CLEAR;
               end else if (cnt == '0) begin
                  pass  <= 1'b0;
                  state <= S_CLEAR;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            // The comparator runs on a slower clock, so wait until both sticky
            // flags are seen low before trusting that it has been cleared.
            S_CLEAR: begin
               if (!match && !not_match) begin
                  if (pass) begin
                     fail_count <= '0;
                     state      <= S_UNLOCK;
                     cnt        <= LOAD_UNLOCK;
                  end else if (fail_count < LAST_FAIL) begin
                     fail_count <= fail_count + 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     fail_count <= FAIL_SAT;
                     state      <= S_LOCKOUT;
                     cnt        <= LOAD_LOCKOUT;
                  end
               end
            end

            S_UNLOCK: begin
               if (cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_LOCKOUT: begin
               if (cnt == '0) begin
                  state      <= S_IDLE;
                  fail_count <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign check      = (state == S_CHECK);
   assign cmp_clear  = (state == S_CLEAR) || rst_clr;
   assign unlocked   = (state == S_UNLOCK);
   assign locked_out = (state == S_LOCKOUT);
   assign alarm      = (state == S_LOCKOUT);
   assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_security_lock_ctrl.sv
// ----------------------------------------------------------------------------
// tb_security_lock_ctrl
//
// Purpose:
//   Self-checking bench for security_lock_ctrl. Every clock is compared
//   against a behavioural model; directed vectors and hand-written sequences
//   additionally compare against fixed expected output words.
//
// Output word layout (8 bits):
//   {check, cmp_clear, unlocked, locked_out, alarm, busy, fail_count[1:0]}
// ----------------------------------------------------------------------------
module tb_security_lock_ctrl;

   localparam int MAX_TRIES      = 3;
   localparam int UNLOCK_CYCLES  = 8;
   localparam int LOCKOUT_CYCLES = 16;
   localparam int RESP_TIMEOUT   = 32;

   logic       clk;
   logic       reset;
   logic       enter;
   logic       match;
   logic       not_match;
   logic       check;
   logic       cmp_clear;
   logic       unlocked;
   logic       locked_out;
   logic       alarm;
   logic       busy;
   logic [1:0] fail_count;

   logic [7:0] outv;
   assign outv = {check, cmp_clear, unlocked, locked_out, alarm, busy, fail_count};

   int errors = 0;
   int checks = 0;

   security_lock_ctrl #(
      .MAX_TRIES      (MAX_TRIES),
      .UNLOCK_CYCLES  (UNLOCK_CYCLES),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
      .RESP_TIMEOUT   (RESP_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enter      (enter),
      .match      (match),
      .not_match  (not_match),
      .check      (check),
      .cmp_clear  (cmp_clear),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .alarm      (alarm),
      .busy       (busy),
      .fail_count (fail_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Behavioural model: an activity name, the number of clocks spent in
   // it so far, and the failure tally.
   // activity: 0 waiting for entry, 1 awaiting comparator verdict,
   //           2 clearing comparator, 3 door open, 4 locked out
   // ------------------------------------------------------------------
   int m_act     = 0;
   int m_elapsed = 0;
   int m_fails   = 0;
   bit m_pass    = 0;
   bit m_rst     = 0;

   task automatic model_step(input bit r, input bit e, input bit mt, input bit nm);
      if (r) begin
         m_act = 0; m_elapsed = 0; m_fails = 0; m_pass = 0; m_rst = 1;
         return;
      end
      m_rst = 0;
      case (m_act)
         0: if (e) begin m_act = 1; m_elapsed = 0; end
         1: begin
            m_elapsed++;
            if (mt)                             begin m_pass = 1; m_act = 2; end
            else if (nm)                        begin m_pass = 0; m_act = 2; end
            else if (m_elapsed == RESP_TIMEOUT) begin m_pass = 0; m_act = 2; end
         end
         2: if (!mt && !nm) begin
            m_elapsed = 0;
            if (m_pass) begin
               m_fails = 0; m_act = 3;
            end else begin
               m_fails++;
               m_act = (m_fails >= MAX_TRIES) ? 4 : 0;
            end
         end
         3: begin
            m_elapsed++;
            if (m_elapsed == UNLOCK_CYCLES) m_act = 0;
         end
         4: begin
            m_elapsed++;
            if (m_elapsed == LOCKOUT_CYCLES) begin m_act = 0; m_fails = 0; end
         end
         default: m_act = 0;
      endcase
   endtask

   function automatic logic [7:0] model_out();
      return {m_act == 1, (m_act == 2) || m_rst, m_act == 3, m_act == 4,
              m_act == 4, m_act != 0, 2'(m_fails)};
   endfunction

   task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one clock of inputs, advance the model, sample 1 time unit later.
   task automatic cycle(input bit r, input bit e, input bit mt, input bit nm);
      reset = r; enter = e; match = mt; not_match = nm;
      @(posedge clk);
      model_step(r, e, mt, nm);
      #1;
      compare("model", outv, model_out());
   endtask

   task automatic cyc_exp(input string name, input bit r, input bit e, input bit mt,
                          input bit nm, input logic [7:0] exp);
      cycle(r, e, mt, nm);
      compare(name, outv, exp);
   endtask

   typedef struct {
      logic       r;
      logic       e;
      logic       m;
      logic       n;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[13];

   initial begin
      // Basic pass: enter, match next edge, flags low, 8 cycles unlocked.
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h40};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h84};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h44};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h24};
      for (int i = 5; i < 12; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h24};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

      reset = 1'b1; enter = 1'b0; match = 1'b0; not_match = 1'b0;
      cycle(1, 0, 0, 0);

      for (int i = 0; i < 13; i++)
         cyc_exp("vec_pass", tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].n, tbl[i].exp);

      // Three failures lead to lockout; enter pulses in lockout are ignored.
      for (int a = 0; a < 2; a++) begin
         cyc_exp("fail_enter", 0, 1, 0, 0, 8'h84 | 8'(a));
         cyc_exp("fail_flag",  0, 0, 0, 1, 8'h44 | 8'(a));
         cyc_exp("fail_done",  0, 0, 0, 0, 8'h00 | 8'(a + 1));
      end
      cyc_exp("lock_enter", 0, 1, 0, 0, 8'h86);
      cyc_exp("lock_flag",  0, 0, 0, 1, 8'h46);
      cyc_exp("lock_start", 0, 0, 0, 0, 8'h1F);
      for (int i = 1; i < LOCKOUT_CYCLES; i++)
         cyc_exp("lock_hold", 0, (i % 3) == 0, 0, 0, 8'h1F);
      cyc_exp("lock_exit", 0, 0, 0, 0, 8'h00);
      cyc_exp("lock_no_queue", 0, 0, 0, 0, 8'h00);

      // Two failures then a pass: count returns to 0, no lockout.
      for (int a = 0; a < 2; a++) begin
         cyc_exp("ff_enter", 0, 1, 0, 0, 8'h84 | 8'(a));
         cyc_exp("ff_flag",  0, 0, 0, 1, 8'h44 | 8'(a));
         cyc_exp("ff_done",  0, 0, 0, 0, 8'h00 | 8'(a + 1));
      end
      cyc_exp("ffp_enter", 0, 1, 0, 0, 8'h86);
      cyc_exp("ffp_match", 0, 0, 1, 0, 8'h46);
      cyc_exp("ffp_open",  0, 0, 0, 0, 8'h24);
      for (int i = 1; i < UNLOCK_CYCLES; i++) cyc_exp("ffp_hold", 0, 0, 0, 0, 8'h24);
      cyc_exp("ffp_close", 0, 0, 0, 0, 8'h00);

      // Response timeout counts as a failure.
      cyc_exp("to_enter", 0, 1, 0, 0, 8'h84);
      for (int i = 1; i < RESP_TIMEOUT; i++) cyc_exp("to_wait", 0, 0, 0, 0, 8'h84);
      cyc_exp("to_fire", 0, 0, 0, 0, 8'h44);
      cyc_exp("to_done", 0, 0, 0, 0, 8'h01);

      // Both flags high -> pass; flags held in CLEAR keep cmp_clear high.
      cyc_exp("both_enter", 0, 1, 0, 0, 8'h85);
      cyc_exp("both_flag",  0, 0, 1, 1, 8'h45);
      for (int i = 0; i < 5; i++) cyc_exp("both_hold", 0, 0, 1, 1, 8'h45);
      cyc_exp("both_open", 0, 0, 0, 0, 8'h24);
      for (int i = 1; i < UNLOCK_CYCLES; i++) cycle(0, 0, 0, 0);
      cyc_exp("both_close", 0, 0, 0, 0, 8'h00);

      // Reset midway through lockout.
      for (int a = 0; a < 3; a++) begin
         cycle(0, 1, 0, 0);
         cycle(0, 0, 0, 1);
         cycle(0, 0, 0, 0);
      end
      compare("rl_locked", outv, 8'h1F);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
      cyc_exp("rl_reset", 1, 0, 0, 0, 8'h40);
      cyc_exp("rl_idle",  0, 0, 0, 0, 8'h00);
      cyc_exp("rl_enter", 0, 1, 0, 0, 8'h84);
      cyc_exp("rl_match", 0, 0, 1, 0, 8'h44);
      cyc_exp("rl_open",  0, 0, 0, 0, 8'h24);

      // Reset midway through unlock.
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
      cyc_exp("ru_reset", 1, 0, 0, 0, 8'h40);
      cyc_exp("ru_idle",  0, 0, 0, 0, 8'h00);
      cyc_exp("ru_enter", 0, 1, 0, 0, 8'h84);
      cyc_exp("ru_match", 0, 0, 1, 0, 8'h44);
      cyc_exp("ru_open",  0, 0, 0, 0, 8'h24);

      // Randomized traffic; flag activity varies per block so that
      // timeouts and long CLEAR holds both occur.
      for (int blk = 0; blk < 24; blk++) begin
         int fprob;
         fprob = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 8 : 3);
         for (int i = 0; i < 100; i++) begin
            bit r, e, mt, nm;
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 3) == 0);
            mt = (fprob != 0) && ($urandom_range(0, fprob - 1) == 0);
            nm = (fprob != 0) && ($urandom_range(0, fprob - 1) == 0);
            cycle(r, e, mt, nm);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
